// File: rtl/control_pipeline_stage.sv
// control_pipeline_stage
//   Decode/control stage of the pipelined MIPS core. Decodes the ID-stage
//   instruction into its control bundle and registers it, together with the
//   register specifiers, into the ID/EX pipeline register. Also detects
//   load-use hazards, decodes JAL/JR linkage and counts illegal instructions.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   instruction       : ID-stage instruction word
//   valid_in          : instruction is real (not a bubble)
//   stall_in          : downstream stall, ID/EX holds
//   flush_in          : taken branch/jump, ID/EX loads a bubble
//   hazard_stall      : combinational load-use stall request to IF/ID and PC
//   ex_*              : registered ID/EX control bundle and specifiers
//   illegal_pulse     : one-cycle pulse after an illegal instruction is accepted
//   illegal_count     : saturating count of accepted illegal instructions
module control_pipeline_stage #(
   parameter int ALU_OP_WIDTH      = 3,
   parameter int REG_ADDR_WIDTH    = 5,
   parameter int SUPPORT_LINK      = 1,
   parameter int ILLEGAL_CNT_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  instruction,
   input  logic                         valid_in,
   input  logic                         stall_in,
   input  logic                         flush_in,
   output logic                         hazard_stall,
   output logic                         ex_valid,
   output logic                         ex_reg_write,
   output logic                         ex_mem_to_reg,
   output logic                         ex_mem_write,
   output logic                         ex_alu_src,
   output logic                         ex_reg_dest,
   output logic                         ex_branch,
   output logic                         ex_branch_ne,
   output logic                         ex_jump,
   output logic                         ex_link,
   output logic                         ex_jump_reg,
   output logic [ALU_OP_WIDTH-1:0]      ex_alu_op,
   output logic [REG_ADDR_WIDTH-1:0]    ex_rs,
   output logic [REG_ADDR_WIDTH-1:0]    ex_rt,
   output logic [REG_ADDR_WIDTH-1:0]    ex_rd,
   output logic [REG_ADDR_WIDTH-1:0]    ex_write_reg,
   output logic                         illegal_pulse,
   output logic [ILLEGAL_CNT_WIDTH-1:0] illegal_count
);

   // ALU operation codes (shared with the execute stage)
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND     = ALU_OP_WIDTH'(3'b000);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR      = ALU_OP_WIDTH'(3'b001);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD     = ALU_OP_WIDTH'(3'b010);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LUI     = ALU_OP_WIDTH'(3'b011);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOR     = ALU_OP_WIDTH'(3'b100);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_UNKNOWN = ALU_OP_WIDTH'(3'b101);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB     = ALU_OP_WIDTH'(3'b110);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT     = ALU_OP_WIDTH'(3'b111);

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] FN_JR      = 6'b001000;

   typedef struct packed {
      logic                      valid;
      logic                      reg_write;
      logic                      mem_to_reg;
      logic                      mem_write;
      logic                      alu_src;
      logic                      reg_dest;
      logic                      branch;
      logic                      branch_ne;
      logic                      jump;
      logic                      link;
      logic                      jump_reg;
      logic [ALU_OP_WIDTH-1:0]   alu_op;
      logic [REG_ADDR_WIDTH-1:0] rs;
      logic [REG_ADDR_WIDTH-1:0] rt;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [REG_ADDR_WIDTH-1:0] write_reg;
   } ctrl_t;

   function automatic logic [ALU_OP_WIDTH-1:0] funct_alu_op(input logic [5:0] funct);
      case (funct)
         6'b100000, 6'b100001: funct_alu_op = ALU_OP_ADD;
         6'b100010:            funct_alu_op = ALU_OP_SUB;
         6'b100100:            funct_alu_op = ALU_OP_AND;
         6'b100101:            funct_alu_op = ALU_OP_OR;
         6'b100111:            funct_alu_op = ALU_OP_NOR;
         6'b101010:            funct_alu_op = ALU_OP_SLT;
         default:              funct_alu_op = ALU_OP_UNKNOWN;
      endcase
   endfunction

   ctrl_t                         dec;
   logic                          legal;
   logic                          uses_rs;
   logic                          uses_rt;
   logic                          hazard;
   ctrl_t                         ex_d, ex_q;
   logic                          illegal_pulse_d, illegal_pulse_q;
   logic [ILLEGAL_CNT_WIDTH-1:0]  illegal_count_d, illegal_count_q;
   logic [5:0]                    opcode;
   logic [5:0]                    funct;
   logic                          unused_shamt;

   assign opcode       = instruction[31:26];
   assign funct        = instruction[5:0];
   assign unused_shamt = ^instruction[10:6];

   // Combinational decode
   always_comb begin
      dec     = '0;
      legal   = 1'b0;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            if (funct == FN_JR) begin
               if (SUPPORT_LINK != 0) begin
                  legal        = 1'b1;
                  dec.jump_reg = 1'b1;
                  uses_rs      = 1'b1;
               end
            end else if (funct_alu_op(funct) != ALU_OP_UNKNOWN) begin
               legal         = 1'b1;
               dec.reg_write = 1'b1;
               dec.alu_op    = funct_alu_op(funct);
               uses_rs       = 1'b1;
               uses_rt       = 1'b1;
            end
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
            legal         = 1'b1;
            dec.reg_write = 1'b1;
            dec.reg_dest  = 1'b1;
            dec.alu_src   = 1'b1;
            uses_rs       = 1'b1;
            case (opcode)
               OP_SLTI: dec.alu_op = ALU_OP_SLT;
               OP_ANDI: dec.alu_op = ALU_OP_AND;
               OP_ORI:  dec.alu_op = ALU_OP_OR;
               OP_LUI:  dec.alu_op = ALU_OP_LUI;
               default: dec.alu_op = ALU_OP_ADD;
            endcase
         end
         OP_LW: begin
            legal          = 1'b1;
            dec.reg_write  = 1'b1;
            dec.reg_dest   = 1'b1;
            dec.alu_src    = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.alu_op     = ALU_OP_ADD;
            uses_rs        = 1'b1;
         end
         OP_SW: begin
            legal         = 1'b1;
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_op    = ALU_OP_ADD;
            uses_rs       = 1'b1;
            uses_rt       = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            legal         = 1'b1;
            dec.branch    = 1'b1;
            dec.branch_ne = (opcode == OP_BNE);
            dec.alu_op    = ALU_OP_SUB;
            uses_rs       = 1'b1;
            uses_rt       = 1'b1;
         end
         OP_J: begin
            legal    = 1'b1;
            dec.jump = 1'b1;
         end
         OP_JAL: begin
            if (SUPPORT_LINK != 0) begin
               legal         = 1'b1;
               dec.jump      = 1'b1;
               dec.link      = 1'b1;
               dec.reg_write = 1'b1;
            end
         end
         default: ;
      endcase
      dec.valid = 1'b1;
      dec.rs    = REG_ADDR_WIDTH'(instruction[25:21]);
      dec.rt    = REG_ADDR_WIDTH'(instruction[20:16]);
      dec.rd    = REG_ADDR_WIDTH'(instruction[15:11]);
      // Instructions that write nothing carry write_reg 0 so they can never
      // alias a real destination in the hazard compare.
      if (dec.link)
         dec.write_reg = REG_ADDR_WIDTH'(31);
      else if (dec.reg_write)
         dec.write_reg = dec.reg_dest ? dec.rt : dec.rd;
   end

   // Load-use hazard against the load sitting in ID/EX; $0 never conflicts
   always_comb begin
      hazard = valid_in & ex_q.valid & ex_q.mem_to_reg & (ex_q.write_reg != '0) &
               ((uses_rs & (ex_q.write_reg == dec.rs)) |
                (uses_rt & (ex_q.write_reg == dec.rt)));
      hazard_stall = hazard & ~flush_in;
   end

   // ID/EX next-state, priority flush > stall > hazard > decode
   always_comb begin
      ex_d            = ex_q;
      illegal_pulse_d = 1'b0;
      illegal_count_d = illegal_count_q;
      if (flush_in) begin
         ex_d = '0;
      end else if (stall_in) begin
         ex_d = ex_q;
      end else if (hazard) begin
         ex_d = '0;
      end else if (valid_in && legal) begin
         ex_d = dec;
      end else if (valid_in) begin
         ex_d            = '0;
         illegal_pulse_d = 1'b1;
         if (illegal_count_q != '1)
            illegal_count_d = illegal_count_q + 1'b1;
      end else begin
         ex_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q            <= '0;
         illegal_pulse_q <= 1'b0;
         illegal_count_q <= '0;
      end else begin
         ex_q            <= ex_d;
         illegal_pulse_q <= illegal_pulse_d;
         illegal_count_q <= illegal_count_d;
      end
   end

   assign ex_valid      = ex_q.valid;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_to_reg = ex_q.mem_to_reg;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_reg_dest   = ex_q.reg_dest;
   assign ex_branch     = ex_q.branch;
   assign ex_branch_ne  = ex_q.branch_ne;
   assign ex_jump       = ex_q.jump;
   assign ex_link       = ex_q.link;
   assign ex_jump_reg   = ex_q.jump_reg;
   assign ex_alu_op     = ex_q.alu_op;
   assign ex_rs         = ex_q.rs;
   assign ex_rt         = ex_q.rt;
   assign ex_rd         = ex_q.rd;
   assign ex_write_reg  = ex_q.write_reg;
   assign illegal_pulse = illegal_pulse_q;
   assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_control_pipeline_stage.sv
// Directed testbench for control_pipeline_stage. Two instances share all
// inputs: u_lnk (SUPPORT_LINK=1) and u_nol (SUPPORT_LINK=0).
module tb_control_pipeline_stage;

   logic        clk, rst;
   logic [31:0] instruction;
   logic        valid_in, stall_in, flush_in;

   logic       a_hz, a_v, a_rw, a_m2r, a_mw, a_as, a_rd_s, a_br, a_bne, a_j, a_l, a_jr, a_ip;
   logic [2:0] a_op;
   logic [4:0] a_rs, a_rt, a_rd, a_wr;
   logic [7:0] a_cnt;
   logic       b_hz, b_v, b_rw, b_m2r, b_mw, b_as, b_rd_s, b_br, b_bne, b_j, b_l, b_jr, b_ip;
   logic [2:0] b_op;
   logic [4:0] b_rs, b_rt, b_rd, b_wr;
   logic [7:0] b_cnt;

   int tests_run = 0;
   int failed    = 0;

   // flags = {valid, reg_write, mem_to_reg, mem_write, alu_src, reg_dest,
   //          branch, branch_ne, jump, link, jump_reg}
   logic [10:0] a_flags, b_flags;
   assign a_flags = {a_v, a_rw, a_m2r, a_mw, a_as, a_rd_s, a_br, a_bne, a_j, a_l, a_jr};
   assign b_flags = {b_v, b_rw, b_m2r, b_mw, b_as, b_rd_s, b_br, b_bne, b_j, b_l, b_jr};

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;

   control_pipeline_stage #(.ALU_OP_WIDTH(3), .REG_ADDR_WIDTH(5), .SUPPORT_LINK(1),
                            .ILLEGAL_CNT_WIDTH(8)) u_lnk (
      .clk(clk), .rst(rst), .instruction(instruction), .valid_in(valid_in),
      .stall_in(stall_in), .flush_in(flush_in), .hazard_stall(a_hz), .ex_valid(a_v),
      .ex_reg_write(a_rw), .ex_mem_to_reg(a_m2r), .ex_mem_write(a_mw), .ex_alu_src(a_as),
      .ex_reg_dest(a_rd_s), .ex_branch(a_br), .ex_branch_ne(a_bne), .ex_jump(a_j),
      .ex_link(a_l), .ex_jump_reg(a_jr), .ex_alu_op(a_op), .ex_rs(a_rs), .ex_rt(a_rt),
      .ex_rd(a_rd), .ex_write_reg(a_wr), .illegal_pulse(a_ip), .illegal_count(a_cnt));

   control_pipeline_stage #(.ALU_OP_WIDTH(3), .REG_ADDR_WIDTH(5), .SUPPORT_LINK(0),
                            .ILLEGAL_CNT_WIDTH(8)) u_nol (
      .clk(clk), .rst(rst), .instruction(instruction), .valid_in(valid_in),
      .stall_in(stall_in), .flush_in(flush_in), .hazard_stall(b_hz), .ex_valid(b_v),
      .ex_reg_write(b_rw), .ex_mem_to_reg(b_m2r), .ex_mem_write(b_mw), .ex_alu_src(b_as),
      .ex_reg_dest(b_rd_s), .ex_branch(b_br), .ex_branch_ne(b_bne), .ex_jump(b_j),
      .ex_link(b_l), .ex_jump_reg(b_jr), .ex_alu_op(b_op), .ex_rs(b_rs), .ex_rt(b_rt),
      .ex_rd(b_rd), .ex_write_reg(b_wr), .illegal_pulse(b_ip), .illegal_count(b_cnt));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      r_type = {6'b000000, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
      i_type = {op, rs, rt, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic v);
      instruction = ins;
      valid_in    = v;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
      drive(32'h0, 1'b0);
      tick(); tick();
      tests_run++;
      if ({a_flags, a_op, a_wr, a_ip, a_cnt, a_hz} !== 28'd0) begin
         failed++;
         $display("FAIL reset_outputs: got %h required 0", {a_flags, a_op, a_wr, a_ip, a_cnt, a_hz});
      end
      rst = 1'b0;
   endtask

   task automatic test_legal_stream();
      drive(r_type(5'd1, 5'd2, 5'd3, 6'b100000), 1'b1);   // ADD $3,$1,$2
      tick();
      tests_run++;
      if (a_flags !== 11'b11000000000) begin
         failed++; $display("FAIL add_flags: got %b required %b", a_flags, 11'b11000000000);
      end
      tests_run++;
      if ({a_op, a_rs, a_rt, a_rd, a_wr} !== {OP_ADD, 5'd1, 5'd2, 5'd3, 5'd3}) begin
         failed++; $display("FAIL add_fields: got %h required %h", {a_op, a_rs, a_rt, a_rd, a_wr},
                            {OP_ADD, 5'd1, 5'd2, 5'd3, 5'd3});
      end
      drive(i_type(6'b100011, 5'd1, 5'd4, 16'd8), 1'b1);  // LW $4,8($1)
      tick();
      tests_run++;
      if (a_flags !== 11'b11101100000) begin
         failed++; $display("FAIL lw_flags: got %b required %b", a_flags, 11'b11101100000);
      end
      tests_run++;
      if ({a_op, a_wr} !== {OP_ADD, 5'd4}) begin
         failed++; $display("FAIL lw_fields: got %h required %h", {a_op, a_wr}, {OP_ADD, 5'd4});
      end
      // SW reads $4 which the LW in EX is still loading: one bubble first
      drive(i_type(6'b101011, 5'd2, 5'd4, 16'd4), 1'b1);  // SW $4,4($2)
      #1;
      tests_run++;
      if (a_hz !== 1'b1) begin
         failed++; $display("FAIL sw_after_lw_hazard: got %b required 1", a_hz);
      end
      tick();
      tests_run++;
      if (a_v !== 1'b0) begin
         failed++; $display("FAIL sw_bubble: got %b required 0", a_v);
      end
      tick();
      tests_run++;
      if (a_flags !== 11'b10011000000) begin
         failed++; $display("FAIL sw_flags: got %b required %b", a_flags, 11'b10011000000);
      end
   endtask

   task automatic test_load_use();
      drive(i_type(6'b100011, 5'd1, 5'd5, 16'd0), 1'b1);  // LW $5,0($1)
      tick();
      drive(r_type(5'd5, 5'd2, 5'd6, 6'b100000), 1'b1);   // ADD $6,$5,$2
      #1;
      tests_run++;
      if (a_hz !== 1'b1) begin
         failed++; $display("FAIL loaduse_stall: got %b required 1", a_hz);
      end
      tick();
      tests_run++;
      if ({a_v, a_hz} !== 2'b00) begin
         failed++; $display("FAIL loaduse_bubble: got %b required 00", {a_v, a_hz});
      end
      tick();
      tests_run++;
      if ({a_v, a_rs, a_wr} !== {1'b1, 5'd5, 5'd6}) begin
         failed++; $display("FAIL loaduse_resume: got %h required %h", {a_v, a_rs, a_wr}, {1'b1, 5'd5, 5'd6});
      end
      // load to $0 never conflicts
      drive(i_type(6'b100011, 5'd1, 5'd0, 16'd0), 1'b1);  // LW $0,0($1)
      tick();
      drive(r_type(5'd0, 5'd2, 5'd6, 6'b100000), 1'b1);   // ADD $6,$0,$2
      #1;
      tests_run++;
      if (a_hz !== 1'b0) begin
         failed++; $display("FAIL zero_reg_hazard: got %b required 0", a_hz);
      end
      tick();
      tests_run++;
      if (a_v !== 1'b1) begin
         failed++; $display("FAIL zero_reg_load: got %b required 1", a_v);
      end
      // flush masks the stall request and loads a bubble
      drive(i_type(6'b100011, 5'd1, 5'd5, 16'd0), 1'b1);
      tick();
      drive(r_type(5'd5, 5'd2, 5'd6, 6'b100000), 1'b1);
      flush_in = 1'b1;
      #1;
      tests_run++;
      if (a_hz !== 1'b0) begin
         failed++; $display("FAIL flush_masks_hazard: got %b required 0", a_hz);
      end
      tick();
      flush_in = 1'b0;
      tests_run++;
      if (a_flags !== 11'd0) begin
         failed++; $display("FAIL flush_bubble: got %b required 0", a_flags);
      end
   endtask

   task automatic test_stall();
      drive(i_type(6'b000101, 5'd1, 5'd2, 16'd3), 1'b1);  // BNE $1,$2,3
      tick();
      drive(r_type(5'd1, 5'd2, 5'd7, 6'b100000), 1'b1);   // ADD $7,$1,$2
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if ({a_flags, a_op} !== {11'b10000011000, OP_SUB}) begin
            failed++; $display("FAIL stall_hold_%0d: got %h required %h", i, {a_flags, a_op},
                               {11'b10000011000, OP_SUB});
         end
      end
      stall_in = 1'b0;
      tick();
      tests_run++;
      if ({a_flags, a_wr} !== {11'b11000000000, 5'd7}) begin
         failed++; $display("FAIL stall_release: got %h required %h", {a_flags, a_wr}, {11'b11000000000, 5'd7});
      end
   endtask

   task automatic test_illegal();
      drive(32'hFC00_0000, 1'b1);                          // opcode 111111
      tick();
      drive(32'h0, 1'b0);
      tests_run++;
      if ({a_ip, a_v, a_cnt} !== {1'b1, 1'b0, 8'd1}) begin
         failed++; $display("FAIL illegal_once: got %h required %h", {a_ip, a_v, a_cnt}, {1'b1, 1'b0, 8'd1});
      end
      tick();
      tests_run++;
      if ({a_ip, a_cnt} !== {1'b0, 8'd1}) begin
         failed++; $display("FAIL illegal_pulse_end: got %h required %h", {a_ip, a_cnt}, {1'b0, 8'd1});
      end
      // held illegal instruction counts once, on release
      drive(32'hFC00_0000, 1'b1);
      stall_in = 1'b1;
      tick(); tick();
      tests_run++;
      if ({a_ip, a_cnt} !== {1'b0, 8'd1}) begin
         failed++; $display("FAIL illegal_stalled: got %h required %h", {a_ip, a_cnt}, {1'b0, 8'd1});
      end
      stall_in = 1'b0;
      tick();
      drive(32'h0, 1'b0);
      tests_run++;
      if ({a_ip, a_cnt} !== {1'b1, 8'd2}) begin
         failed++; $display("FAIL illegal_released: got %h required %h", {a_ip, a_cnt}, {1'b1, 8'd2});
      end
      drive(32'hFC00_0000, 1'b1);
      for (int i = 0; i < 260; i++) tick();
      tests_run++;
      if ({a_ip, a_cnt} !== {1'b1, 8'd255}) begin
         failed++; $display("FAIL illegal_saturate: got %h required %h", {a_ip, a_cnt}, {1'b1, 8'd255});
      end
      drive(32'h0, 1'b0);
      tick();
   endtask

   task automatic test_link();
      drive({6'b000011, 26'h10}, 1'b1);                    // JAL
      tick();
      tests_run++;
      if ({a_flags, a_wr} !== {11'b11000000110, 5'd31}) begin
         failed++; $display("FAIL jal_link: got %h required %h", {a_flags, a_wr}, {11'b11000000110, 5'd31});
      end
      tests_run++;
      if ({b_ip, b_v} !== 2'b10) begin
         failed++; $display("FAIL jal_nolink_illegal: got %b required 10", {b_ip, b_v});
      end
      drive(r_type(5'd31, 5'd0, 5'd0, 6'b001000), 1'b1);  // JR $31
      tick();
      tests_run++;
      if ({a_flags, a_rs, a_ip} !== {11'b10000000001, 5'd31, 1'b0}) begin
         failed++; $display("FAIL jr_link: got %h required %h", {a_flags, a_rs, a_ip},
                            {11'b10000000001, 5'd31, 1'b0});
      end
      tests_run++;
      if ({b_ip, b_v} !== 2'b10) begin
         failed++; $display("FAIL jr_nolink_illegal: got %b required 10", {b_ip, b_v});
      end
   endtask

   task automatic test_async_reset();
      drive(r_type(5'd1, 5'd2, 5'd3, 6'b100000), 1'b1);
      tick();
      rst = 1'b1;
      #1;
      tests_run++;
      if ({a_flags, a_op, a_rs, a_rt, a_rd, a_wr, a_ip, a_cnt, a_hz} !== 43'd0) begin
         failed++; $display("FAIL async_reset: got %h required 0",
                            {a_flags, a_op, a_rs, a_rt, a_rd, a_wr, a_ip, a_cnt, a_hz});
      end
      tests_run++;
      if (b_cnt !== 8'd0) begin
         failed++; $display("FAIL async_reset_cnt_b: got %h required 0", b_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(32'h0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_legal_stream();
      test_load_use();
      test_stall();
      test_illegal();
      test_link();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
